// File: rtl/jk_count_ctrl.sv
// Controller for an external bank of JK flip-flops: loads a value via set/reset
// excitation or counts up/down modulo M via toggle excitation.
module jk_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_up,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             ff_clear_n,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic             busy_reg;
    logic             done_reg;
    logic             ff_clear_n_reg;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH-1:0] m_last;
    logic             out_of_range;
    logic             wrap_up;
    logic             wrap_dn;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] toggle_mask;
    logic             in_load;
    logic             in_run;

    // ------------------------------------------------------------------
    // Modulus arithmetic. A zero modulus means the full 2^WIDTH range,
    // which the extra top bit of m_ext represents.
    // ------------------------------------------------------------------
    assign m_ext        = (modulus == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, modulus};
    assign m_last       = modulus - WIDTH'(1);
    assign out_of_range = ({1'b0, q_fb} >= m_ext);
    assign wrap_up      = (q_fb == m_last);
    assign wrap_dn      = (q_fb == '0);

    always_comb begin
        count_next = '0;
        if (out_of_range) begin
            count_next = '0;
        end else if (mode_up) begin
            count_next = wrap_up ? '0 : q_fb + WIDTH'(1);
        end else begin
            count_next = wrap_dn ? m_last : q_fb - WIDTH'(1);
        end
    end

    assign toggle_mask = q_fb ^ count_next;
    assign in_load     = (state_reg == LOAD) && !clear;
    assign in_run      = (state_reg == RUN) && !clear;

    // Per-bit excitation: set/reset pairs while loading, toggles while counting,
    // and J=K=0 (hold) everywhere else.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
            assign j_out[gi] = (in_load &&  load_val[gi] && !q_fb[gi]) ||
                               (in_run  &&  toggle_mask[gi]);
            assign k_out[gi] = (in_load && !load_val[gi] &&  q_fb[gi]) ||
                               (in_run  &&  toggle_mask[gi]);
        end
    endgenerate

    assign tc = in_run && !out_of_range && (mode_up ? wrap_up : wrap_dn);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load_en) begin
                    state_next = LOAD;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            LOAD:    state_next = IDLE;
            RUN: begin
                if (stop) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy mirrors the state being entered so it lines up with LOAD/RUN;
    // done fires on the cycle after FLUSH.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            ff_clear_n_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            busy_reg       <= (state_next == LOAD) || (state_next == RUN);
            done_reg       <= (state_reg == FLUSH);
            ff_clear_n_reg <= 1'b1;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign ff_clear_n = ff_clear_n_reg;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Bench for jk_count_ctrl: drives a behavioural JK bank and compares against
// a value-level model of the counter (directed scenarios plus random traffic).
module tb_jk_count_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         mode_up = 1'b0;
    logic         load_en = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] modulus = '0;
    logic [W-1:0] q_fb = '0;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic         ff_clear_n;
    logic         busy;
    logic         tc;
    logic         done;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    jk_count_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .clear(clear), .start(start), .stop(stop), .mode_up(mode_up),
        .load_en(load_en), .load_val(load_val), .modulus(modulus), .q_fb(q_fb),
        .j_out(j_out), .k_out(k_out), .ff_clear_n(ff_clear_n), .busy(busy),
        .tc(tc), .done(done)
    );

    // External JK bank with asynchronous active-low clear.
    always @(posedge clk or negedge ff_clear_n) begin
        if (!ff_clear_n) begin
            q_fb <= '0;
        end else begin
            for (int b = 0; b < W; b++) begin
                case ({j_out[b], k_out[b]})
                    2'b10:   q_fb[b] <= 1'b1;
                    2'b01:   q_fb[b] <= 1'b0;
                    2'b11:   q_fb[b] <= ~q_fb[b];
                    default: q_fb[b] <= q_fb[b];
                endcase
            end
        end
    end

    // Counting rule expressed as plain integer arithmetic.
    function automatic logic [W-1:0] ref_next(input int q, input bit up, input int m);
        int mm;
        mm = (m == 0) ? (1 << W) : m;
        if (q >= mm) return '0;
        if (up) return W'((q == mm - 1) ? 0 : q + 1);
        return W'((q == 0) ? mm - 1 : q - 1);
    endfunction

    function automatic bit ref_tc(input int q, input bit up, input int m);
        int mm;
        mm = (m == 0) ? (1 << W) : m;
        return (q < mm) && (up ? (q == mm - 1) : (q == 0));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        cyc();
        cyc();
        total_cnt++; if (ff_clear_n !== 1'b0) $display("FAIL reset_fcn: got %b want 0", ff_clear_n); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (q_fb !== 4'd0) $display("FAIL reset_q: got %h want 0", q_fb); else pass_cnt++;
        total_cnt++; if ({j_out, k_out} !== 8'h00) $display("FAIL reset_jk: got %h want 00", {j_out, k_out}); else pass_cnt++;
        clear = 1'b0;
        cyc();
        total_cnt++; if (ff_clear_n !== 1'b1) $display("FAIL reset_release_fcn: got %b want 1", ff_clear_n); else pass_cnt++;
    endtask

    task automatic test_count_up();
        logic [W-1:0] exp_q;
        logic [W-1:0] nx;
        modulus = 4'd10;
        mode_up = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL up_busy: got %b want 1", busy); else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_q = W'(i % 10);
            nx = ref_next(exp_q, 1'b1, 10);
            total_cnt++; if (q_fb !== exp_q) $display("FAIL up_q[%0d]: got %h want %h", i, q_fb, exp_q); else pass_cnt++;
            total_cnt++; if (tc !== (exp_q == 4'd9)) $display("FAIL up_tc[%0d]: got %b want %b", i, tc, exp_q == 4'd9); else pass_cnt++;
            total_cnt++; if (j_out !== (exp_q ^ nx) || k_out !== (exp_q ^ nx))
                $display("FAIL up_jk[%0d]: got j=%h k=%h want %h", i, j_out, k_out, exp_q ^ nx); else pass_cnt++;
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        total_cnt++; if (q_fb !== 4'd3) $display("FAIL up_stop_q: got %h want 3", q_fb); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL up_flush: got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
        cyc();
        total_cnt++; if (done !== 1'b1) $display("FAIL up_done: got %b want 1", done); else pass_cnt++;
        cyc();
        total_cnt++; if (done !== 1'b0) $display("FAIL up_done_pulse: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_down_full_range();
        load_val = 4'd0;
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
        cyc();
        modulus = 4'd0;
        mode_up = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b1;
        #1;
        total_cnt++; if (j_out !== 4'hF || k_out !== 4'hF) $display("FAIL down_jk: got j=%h k=%h want f f", j_out, k_out); else pass_cnt++;
        total_cnt++; if (tc !== 1'b1) $display("FAIL down_tc: got %b want 1", tc); else pass_cnt++;
        cyc();
        stop = 1'b0;
        total_cnt++; if (q_fb !== 4'hF) $display("FAIL down_q: got %h want f", q_fb); else pass_cnt++;
        cyc();
        total_cnt++; if (done !== 1'b1) $display("FAIL down_done: got %b want 1", done); else pass_cnt++;
        cyc();
    endtask

    task automatic test_load();
        load_val = 4'd5;
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
        cyc();
        total_cnt++; if (q_fb !== 4'd5) $display("FAIL load_first_q: got %h want 5", q_fb); else pass_cnt++;
        load_val = 4'hC;
        load_en = 1'b1;
        #1;
        total_cnt++; if ({j_out, k_out} !== 8'h00) $display("FAIL load_idle_hold: got %h want 00", {j_out, k_out}); else pass_cnt++;
        cyc();
        load_en = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL load_busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (j_out !== 4'b1000 || k_out !== 4'b0001) $display("FAIL load_jk: got j=%b k=%b want 1000 0001", j_out, k_out); else pass_cnt++;
        cyc();
        total_cnt++; if (q_fb !== 4'hC) $display("FAIL load_q: got %h want c", q_fb); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL load_busy_end: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_stop();
        load_val = 4'd3;
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
        cyc();
        modulus = 4'd10;
        mode_up = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b1;
        #1;
        total_cnt++; if (q_fb !== 4'd3 || tc !== 1'b0) $display("FAIL stop_pre: got q=%h tc=%b want 3 0", q_fb, tc); else pass_cnt++;
        cyc();
        stop = 1'b0;
        total_cnt++; if (q_fb !== 4'd4) $display("FAIL stop_q: got %h want 4", q_fb); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL stop_flush: got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
        cyc();
        total_cnt++; if (done !== 1'b1) $display("FAIL stop_done: got %b want 1", done); else pass_cnt++;
        cyc();
        total_cnt++; if (done !== 1'b0 || q_fb !== 4'd4) $display("FAIL stop_hold: got done=%b q=%h want 0 4", done, q_fb); else pass_cnt++;
        cyc();
        total_cnt++; if (q_fb !== 4'd4) $display("FAIL stop_hold2: got %h want 4", q_fb); else pass_cnt++;
    endtask

    task automatic test_priority();
        load_val = 4'd7;
        load_en = 1'b1;
        start = 1'b1;
        cyc();
        load_en = 1'b0;
        start = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b1 || j_out !== 4'd3 || k_out !== 4'd0)
            $display("FAIL prio_load: got busy=%b j=%h k=%h want 1 3 0", busy, j_out, k_out); else pass_cnt++;
        cyc();
        total_cnt++; if (q_fb !== 4'd7 || busy !== 1'b0) $display("FAIL prio_idle: got q=%h busy=%b want 7 0", q_fb, busy); else pass_cnt++;
        cyc();
        total_cnt++; if (busy !== 1'b0 || q_fb !== 4'd7) $display("FAIL prio_no_run: got busy=%b q=%h want 0 7", busy, q_fb); else pass_cnt++;
        load_val = 4'd2;
        load_en = 1'b1;
        start = 1'b1;
        cyc();
        load_en = 1'b0;
        cyc();
        total_cnt++; if (busy !== 1'b0 || q_fb !== 4'd2) $display("FAIL prio_idle2: got busy=%b q=%h want 0 2", busy, q_fb); else pass_cnt++;
        cyc();
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL prio_run: got %b want 1", busy); else pass_cnt++;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_clear_mid_run();
        load_val = 4'd6;
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
        cyc();
        modulus = 4'd10;
        mode_up = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        total_cnt++; if (q_fb !== 4'd6 || busy !== 1'b1) $display("FAIL clr_pre: got q=%h busy=%b want 6 1", q_fb, busy); else pass_cnt++;
        clear = 1'b1;
        #1;
        total_cnt++; if ({j_out, k_out} !== 8'h00) $display("FAIL clr_jk: got %h want 00", {j_out, k_out}); else pass_cnt++;
        cyc();
        clear = 1'b0;
        total_cnt++; if (ff_clear_n !== 1'b0 || q_fb !== 4'd0) $display("FAIL clr_bank: got fcn=%b q=%h want 0 0", ff_clear_n, q_fb); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL clr_flags: got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total_cnt++; if (done !== 1'b0 || busy !== 1'b0 || q_fb !== 4'd0 || ff_clear_n !== 1'b1)
                $display("FAIL clr_after[%0d]: got done=%b busy=%b q=%h fcn=%b want 0 0 0 1", i, done, busy, q_fb, ff_clear_n); else pass_cnt++;
        end
    endtask

    // Random traffic checked against a phase + value model of the controller.
    task automatic test_random();
        int           ph;
        int           prev_ph;
        logic [W-1:0] mq;
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        logic [W-1:0] nx;
        bit           etc_v;
        bit           ebusy;
        bit           edone;
        bit           efcn;
        ph = 0;
        mq = '0;
        for (int n = 0; n < 400; n++) begin
            clear    = ($urandom_range(0, 39) == 0);
            start    = ($urandom_range(0, 2) == 0);
            stop     = ($urandom_range(0, 5) == 0);
            load_en  = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom_range(0, 15));
            mode_up  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) modulus = W'($urandom_range(0, 15));
            #1;
            nx = ref_next(mq, mode_up, modulus);
            ej = '0;
            ek = '0;
            etc_v = 1'b0;
            if (!clear && ph == 1) begin
                ej = load_val & ~mq;
                ek = ~load_val & mq;
            end else if (!clear && ph == 2) begin
                ej = mq ^ nx;
                ek = mq ^ nx;
                etc_v = ref_tc(mq, mode_up, modulus);
            end
            total_cnt++; if (j_out !== ej || k_out !== ek)
                $display("FAIL rnd_jk[%0d]: got j=%h k=%h want j=%h k=%h", n, j_out, k_out, ej, ek); else pass_cnt++;
            if (!clear) begin
                total_cnt++; if (tc !== etc_v) $display("FAIL rnd_tc[%0d]: got %b want %b", n, tc, etc_v); else pass_cnt++;
            end
            cyc();
            prev_ph = ph;
            if (clear) begin
                ph = 0;
                mq = '0;
                efcn = 1'b0;
                edone = 1'b0;
            end else begin
                efcn = 1'b1;
                case (ph)
                    0: ph = load_en ? 1 : (start ? 2 : 0);
                    1: begin mq = load_val; ph = 0; end
                    2: begin mq = nx; ph = stop ? 3 : 2; end
                    default: ph = 0;
                endcase
                edone = (prev_ph == 3);
            end
            ebusy = (ph == 1) || (ph == 2);
            total_cnt++; if (q_fb !== mq) $display("FAIL rnd_q[%0d]: got %h want %h", n, q_fb, mq); else pass_cnt++;
            total_cnt++; if (busy !== ebusy || done !== edone || ff_clear_n !== efcn)
                $display("FAIL rnd_flags[%0d]: got busy=%b done=%b fcn=%b want %b %b %b", n, busy, done, ff_clear_n, ebusy, edone, efcn); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_down_full_range();
        test_load();
        test_stop();
        test_priority();
        test_clear_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
